// File: rtl/fpga_ip_demo_sysid_arbiter.sv
// Round-robin arbiter sharing one sysid slave between two Avalon-MM readers.
// Three-state transaction: IDLE grant, ACCESS capture, DONE complete.
module fpga_ip_demo_sysid_arbiter #(
   parameter logic [31:0] EXPECTED_ID = 32'd0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        m0_read,
   input  logic        m0_address,
   output logic        m0_waitrequest,
   output logic [31:0] m0_readdata,
   input  logic        m1_read,
   input  logic        m1_address,
   output logic        m1_waitrequest,
   output logic [31:0] m1_readdata,
   output logic        s_address,
   input  logic [31:0] s_readdata,
   output logic        id_mismatch,
   output logic [7:0]  read_count
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   state_t      state_q;
   logic        gnt_q;
   logic        last_q;
   logic        addr_q;
   logic [31:0] data_q;
   logic        wait0_q;
   logic        wait1_q;
   logic [31:0] rd0_q;
   logic [31:0] rd1_q;
   logic        mism_q;
   logic [7:0]  cnt_q;
   logic        gnt_d;

   // On a tie the requester not served last wins; last_q=1 favours m0.
   always_comb begin
      gnt_d = 1'b0;
      if (m0_read && m1_read) begin
         gnt_d = ~last_q;
      end else if (m1_read) begin
         gnt_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         addr_q  <= 1'b0;
         data_q  <= '0;
         wait0_q <= 1'b1;
         wait1_q <= 1'b1;
         rd0_q   <= '0;
         rd1_q   <= '0;
         mism_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (m0_read || m1_read) begin
                  gnt_q   <= gnt_d;
                  addr_q  <= gnt_d ? m1_address : m0_address;
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               data_q  <= s_readdata;
               state_q <= DONE;
               if (gnt_q) begin
                  wait1_q <= 1'b0;
                  rd1_q   <= s_readdata;
               end else begin
                  wait0_q <= 1'b0;
                  rd0_q   <= s_readdata;
               end
            end
            DONE: begin
               wait0_q <= 1'b1;
               wait1_q <= 1'b1;
               rd0_q   <= '0;
               rd1_q   <= '0;
               last_q  <= gnt_q;
               cnt_q   <= cnt_q + 8'd1;
               if (!addr_q && (data_q != EXPECTED_ID)) begin
                  mism_q <= 1'b1;
               end
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign m0_waitrequest = wait0_q;
   assign m1_waitrequest = wait1_q;
   assign m0_readdata    = rd0_q;
   assign m1_readdata    = rd1_q;
   assign s_address      = addr_q;
   assign id_mismatch    = mism_q;
   assign read_count     = cnt_q;

endmodule

// File: tb/tb_fpga_ip_demo_sysid_arbiter.sv
// Directed bench for the sysid arbiter: vector table plus
// tie, reset-abort and counter-wrap sequences.
module tb_fpga_ip_demo_sysid_arbiter;

   localparam logic [31:0] ID  = 32'h6089_6D7A;
   localparam logic [31:0] TS  = 32'h1234_5678;
   localparam logic [31:0] BAD = 32'h0000_0000;
   localparam logic [31:0] DB  = 32'hDEAD_BEEF;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        m0_read = 1'b0;
   logic        m0_address = 1'b0;
   logic        m0_waitrequest;
   logic [31:0] m0_readdata;
   logic        m1_read = 1'b0;
   logic        m1_address = 1'b0;
   logic        m1_waitrequest;
   logic [31:0] m1_readdata;
   logic        s_address;
   logic [31:0] s_readdata;
   logic        id_mismatch;
   logic [7:0]  read_count;
   logic [31:0] id_v = ID;
   logic [31:0] ts_v = TS;

   int checks = 0;
   int failures = 0;

   assign s_readdata = s_address ? ts_v : id_v;

   fpga_ip_demo_sysid_arbiter #(.EXPECTED_ID(ID)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .m0_read        (m0_read),
      .m0_address     (m0_address),
      .m0_waitrequest (m0_waitrequest),
      .m0_readdata    (m0_readdata),
      .m1_read        (m1_read),
      .m1_address     (m1_address),
      .m1_waitrequest (m1_waitrequest),
      .m1_readdata    (m1_readdata),
      .s_address      (s_address),
      .s_readdata     (s_readdata),
      .id_mismatch    (id_mismatch),
      .read_count     (read_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        r0, a0, r1, a1;
      logic [31:0] id, ts;
      logic        w0, w1;
      logic [31:0] d0, d1;
      logic        mm;
      logic [7:0]  cnt;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [79:0] act,
                      input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic do_reset();
      m0_read = 0; m1_read = 0; m0_address = 0; m1_address = 0;
      reset_n = 0;
      repeat (2) @(negedge clock);
      chk("reset_vals",
          {m0_waitrequest, m1_waitrequest, m0_readdata, m1_readdata,
           s_address, id_mismatch, read_count},
          {1'b1, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 8'd0});
      reset_n = 1;
      tick();
   endtask

   initial begin
      tbl[0]  = '{1,0,0,0,ID,TS,  1,1,32'd0,32'd0,0,8'd0};
      tbl[1]  = '{1,0,0,0,ID,TS,  0,1,ID,32'd0,0,8'd0};
      tbl[2]  = '{0,0,0,0,ID,TS,  1,1,32'd0,32'd0,0,8'd1};
      tbl[3]  = '{0,0,1,1,ID,TS,  1,1,32'd0,32'd0,0,8'd1};
      tbl[4]  = '{0,0,1,1,ID,TS,  1,0,32'd0,TS,0,8'd1};
      tbl[5]  = '{0,0,0,0,ID,TS,  1,1,32'd0,32'd0,0,8'd2};
      tbl[6]  = '{1,0,0,0,BAD,TS, 1,1,32'd0,32'd0,0,8'd2};
      tbl[7]  = '{1,0,0,0,BAD,TS, 0,1,BAD,32'd0,0,8'd2};
      tbl[8]  = '{0,0,0,0,BAD,TS, 1,1,32'd0,32'd0,1,8'd3};
      tbl[9]  = '{1,0,0,0,ID,DB,  1,1,32'd0,32'd0,1,8'd3};
      tbl[10] = '{1,1,0,0,ID,DB,  0,1,ID,32'd0,1,8'd3};
      tbl[11] = '{0,0,0,0,ID,DB,  1,1,32'd0,32'd0,1,8'd4};
      tbl[12] = '{0,0,1,0,ID,TS,  1,1,32'd0,32'd0,1,8'd4};
      tbl[13] = '{0,0,0,0,ID,TS,  1,0,32'd0,ID,1,8'd4};
      tbl[14] = '{0,0,0,0,ID,TS,  1,1,32'd0,32'd0,1,8'd5};

      @(negedge clock);
      do_reset();

      for (int i = 0; i < 15; i++) begin
         m0_read = tbl[i].r0; m0_address = tbl[i].a0;
         m1_read = tbl[i].r1; m1_address = tbl[i].a1;
         id_v = tbl[i].id; ts_v = tbl[i].ts;
         tick();
         chk($sformatf("row%0d", i),
             {m0_waitrequest, m1_waitrequest, m0_readdata, m1_readdata,
              1'b0, id_mismatch, read_count},
             {tbl[i].w0, tbl[i].w1, tbl[i].d0, tbl[i].d1,
              1'b0, tbl[i].mm, tbl[i].cnt});
      end

      id_v = ID; ts_v = TS;
      do_reset();

      // Tie from reset: m0 then m1 alternate, each 3 cycles apart.
      m0_read = 1; m1_read = 1;
      for (int k = 0; k < 12; k++) begin
         tick();
         chk($sformatf("tie_c%0d", k),
             {78'd0, m0_waitrequest, m1_waitrequest},
             {78'd0, !(k == 1 || k == 7), !(k == 4 || k == 10)});
      end
      m0_read = 0; m1_read = 0;
      tick();
      chk("tie_count", {72'd0, read_count}, {72'd0, 8'd4});

      // Reset asserted mid-ACCESS aborts without a completion cycle.
      m0_read = 1; m0_address = 0;
      tick();
      reset_n = 0;
      #1;
      chk("abort_async",
          {m0_waitrequest, m1_waitrequest, m0_readdata, m1_readdata,
           1'b0, 1'b0, read_count},
          {1'b1, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 8'd0});
      m0_read = 0;
      repeat (2) @(negedge clock);
      reset_n = 1;
      begin
         int lows = 0;
         for (int k = 0; k < 4; k++) begin
            tick();
            if (!m0_waitrequest || !m1_waitrequest) lows++;
         end
         chk("abort_no_done", {48'd0, 32'(lows)}, 80'd0);
      end
      chk("abort_count", {72'd0, read_count}, {72'd0, 8'd0});

      // 256 back-to-back reads wrap the counter.
      do_reset();
      begin
         int n = 0;
         int last = 0;
         int gap_err = 0;
         m0_read = 1;
         for (int c = 0; c < 256 * 3 + 10 && n < 256; c++) begin
            tick();
            if (!m0_waitrequest) begin
               n++;
               if (n > 1 && (c - last) != 3) gap_err++;
               last = c;
               if (n == 256) begin
                  chk("wrap_pre", {72'd0, read_count}, {72'd0, 8'd255});
                  m0_read = 0;
               end
            end
         end
         chk("wrap_reads", {48'd0, 32'(n)}, {48'd0, 32'd256});
         chk("wrap_gaps", {48'd0, 32'(gap_err)}, 80'd0);
         tick();
         chk("wrap_count", {72'd0, read_count}, {72'd0, 8'd0});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fpga_ip_demo_sysid_arbiter.md
FPGA_IP_DEMO_SYSID_ARBITER -- requirements
Module: fpga_ip_demo_sysid_arbiter

Interface
REQ-001 Parameter EXPECTED_ID, default 32'd0 at instantiation site overridden by system, meaning: required system ID word at sysid address 0.
REQ-002 clock  input  1  single clock for all logic.
REQ-003 reset_n  input  1  one clock; reset is asynchronous and active-low.
REQ-004 m0_read  input  1  requester 0 read request (Avalon-MM).
REQ-005 m0_address  input  1  requester 0 word select (0 = ID, 1 = timestamp).
REQ-006 m0_waitrequest  output  1  requester 0 stall; low for exactly the completion cycle.
REQ-007 m0_readdata  output  32  requester 0 read data, valid when m0_waitrequest low and m0_read high.
REQ-008 m1_read, m1_address, m1_waitrequest, m1_readdata  same directions/widths/meaning for requester 1.
REQ-009 s_address  output  1  address to shared sysid control slave.
REQ-010 s_readdata  input  32  combinational read data from sysid slave.
REQ-011 id_mismatch  output  1  sticky flag: an ID read returned a value other than EXPECTED_ID.
REQ-012 read_count  output  8  count of completed reads, both requesters.

Function
REQ-013 FSM states SHALL be IDLE, ACCESS, DONE; one transaction in flight at a time.
REQ-014 IDLE: if any mN_read high, SHALL register grant, register s_address <= granted mN_address, go ACCESS; else stay IDLE.
REQ-015 Arbitration SHALL be round-robin: only one requesting -> grant it; both requesting -> grant the one not granted last; last_grant resets to 1 (so m0 wins first tie).
REQ-016 ACCESS: s_address held; s_readdata SHALL be captured into a 32-bit data register at the end of the cycle; go DONE.
REQ-017 DONE: granted mN_waitrequest SHALL be low for one cycle with mN_readdata = captured data; go IDLE; update last_grant.
REQ-018 Latency: read sampled in IDLE at cycle T -> waitrequest low at T+2; max throughput one read per 3 cycles.
REQ-019 Non-granted requester's waitrequest SHALL stay high at all times; its request SHALL be served in the next IDLE it is still asserted.
REQ-020 mN_readdata of the non-granted (or idle) requester SHALL be 0.
REQ-021 Requesters SHALL hold read/address until waitrequest low; if a granted read drops before DONE, transaction still completes, data discarded, read_count still increments.
REQ-022 Address change by the granted requester after grant SHALL be ignored (registered address used).
REQ-023 In DONE, if registered address == 0 and captured data != EXPECTED_ID, id_mismatch SHALL set and stay set until reset.
REQ-024 read_count SHALL increment by 1 on every DONE cycle, wrapping 255 -> 0.
REQ-025 Outside a transaction s_address SHALL retain its last value (no glitching required of slave).

Reset
REQ-026 reset_n low SHALL asynchronously force: state IDLE, m0/m1_waitrequest = 1, m0/m1_readdata = 0, s_address = 0, data register = 0, id_mismatch = 0, read_count = 0, last_grant = 1.
REQ-027 Reset mid-transaction SHALL abort it with no completion cycle; after reset release, first evaluation happens in the first IDLE cycle.
REQ-028 All state SHALL be released synchronously on the first rising clock edge after reset_n high; no request is sampled in that cycle's reset.

Verification
REQ-029 Single read: EXPECTED_ID=32'h6089_6D7A, slave returns that for address 0; m0_read=1, m0_address=0 at T -> m0_waitrequest low at T+2, m0_readdata=32'h6089_6D7A, id_mismatch=0, read_count=1.
REQ-030 Tie: m0 and m1 both read from reset -> m0 completes at T+2, m1 at T+5, then both again -> m0 at T+8, m1 at T+11; read_count=4.
REQ-031 Mismatch: slave returns 32'h0000_0000 for address 0 -> id_mismatch rises after the DONE cycle and stays 1 across later correct reads until reset_n pulse.
REQ-032 Timestamp read: m1_address=1, slave returns 32'h1234_5678 -> m1_readdata=32'h1234_5678 at T+2, id_mismatch unchanged.
REQ-033 Reset mid-ACCESS: assert reset_n low during ACCESS -> waitrequests immediately 1, readdata 0, no completion cycle, read_count=0.
REQ-034 Wrap: 256 back-to-back m0 reads -> read_count returns to 0, every read completes exactly 3 cycles apart.
